// File: rtl/cache_fill_fsm.sv
// Cache miss fill controller: stalls the pipeline on a miss, streams one aligned
// 8-word block from main memory into the data array, then writes the tag array.
module cache_fill_fsm #(
  parameter int ADDR_W      = 16,
  parameter int BLOCK_WORDS = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              miss_detected,
  input  logic [ADDR_W-1:0] miss_address,
  output logic              fsm_busy,
  output logic              memory_req,
  output logic [ADDR_W-1:0] memory_address,
  input  logic [15:0]       memory_data,
  input  logic              memory_data_valid,
  output logic              write_data_array,
  output logic [2:0]        fill_word,
  output logic [15:0]       fill_data,
  output logic              write_tag_array,
  output logic [ADDR_W-5:0] fill_tag
);

  typedef enum logic {
    IDLE = 1'b0,
    FILL = 1'b1
  } state_e;

  localparam logic [3:0] NUM_WORDS = 4'(BLOCK_WORDS);
  localparam logic [3:0] LAST_WORD = 4'(BLOCK_WORDS - 1);

  state_e            state, state_next;
  logic [ADDR_W-5:0] base;
  logic [3:0]        req_cnt;
  logic [3:0]        rcv_cnt;

  // The byte-within-block bits of the miss address never matter for a fill.
  logic unused_offset_bits;
  assign unused_offset_bits = ^miss_address[3:0];

  assign fill_tag = base;

  // NOTE: every output is given a default before the case so no path leaves
  // a signal unassigned; that is what keeps this block free of latches.
  always_comb begin
    state_next       = state;
    fsm_busy         = 1'b0;
    memory_req       = 1'b0;
    memory_address   = '0;
    write_data_array = 1'b0;
    fill_word        = '0;
    fill_data        = '0;
    write_tag_array  = 1'b0;

    case (state)
      IDLE: begin
        fsm_busy = miss_detected;
        if (miss_detected) state_next = FILL;
      end
      FILL: begin
        fsm_busy = 1'b1;
        if (req_cnt < NUM_WORDS) begin
          memory_req     = 1'b1;
          memory_address = {base, req_cnt[2:0], 1'b0};
        end
        // Returns are matched to offsets purely by arrival order.
        if (memory_data_valid) begin
          write_data_array = 1'b1;
          fill_word        = rcv_cnt[2:0];
          fill_data        = memory_data;
          if (rcv_cnt == LAST_WORD) begin
            write_tag_array = 1'b1;
            state_next      = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      base    <= '0;
      req_cnt <= '0;
      rcv_cnt <= '0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: begin
          if (miss_detected) begin
            base    <= miss_address[ADDR_W-1:4];
            req_cnt <= '0;
            rcv_cnt <= '0;
          end
        end
        FILL: begin
          // req_cnt stops at NUM_WORDS because memory_req drops there.
          if (memory_req)       req_cnt <= req_cnt + 4'd1;
          if (write_data_array) rcv_cnt <= rcv_cnt + 4'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cache_fill_fsm.sv
// Self-checking bench for cache_fill_fsm: a latency-configurable memory model
// answers requests, and each fill is compared against an arithmetic timeline.
module tb_cache_fill_fsm;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        miss_detected;
  logic [15:0] miss_address;
  logic        fsm_busy;
  logic        memory_req;
  logic [15:0] memory_address;
  logic [15:0] memory_data;
  logic        memory_data_valid;
  logic        write_data_array;
  logic [2:0]  fill_word;
  logic [15:0] fill_data;
  logic        write_tag_array;
  logic [11:0] fill_tag;

  int n_total = 0;
  int n_pass  = 0;

  logic [15:0] mem [0:32767];

  typedef struct {
    logic [15:0] addr;
    int          ready;
  } pend_t;

  always #5 clk = ~clk;

  cache_fill_fsm #(.ADDR_W(16), .BLOCK_WORDS(8)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .miss_detected    (miss_detected),
    .miss_address     (miss_address),
    .fsm_busy         (fsm_busy),
    .memory_req       (memory_req),
    .memory_address   (memory_address),
    .memory_data      (memory_data),
    .memory_data_valid(memory_data_valid),
    .write_data_array (write_data_array),
    .fill_word        (fill_word),
    .fill_data        (fill_data),
    .write_tag_array  (write_tag_array),
    .fill_tag         (fill_tag)
  );

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Runs one fill from the current cycle (cycle 0 = first cycle with miss high).
  // Returns stall for stall_len cycles once word stall_at has been returned.
  // abort_after > 0 asserts reset right after that many data writes.
  task automatic run_fill(input string name, input logic [15:0] addr, input int lat,
                          input int stall_at, input int stall_len, input bit use_alt,
                          input logic [15:0] alt, input bit hold, input int abort_after);
    pend_t       q[$];
    int          nreq = 0, nwr = 0, ntag = 0, nbusy = 0, ret = 0;
    int          stall_left = stall_len;
    int          req_cyc[16], wr_cyc[16];
    logic [15:0] req_addr[16], wr_data[16];
    logic [2:0]  wr_word[16];
    int          tag_cyc = -1;
    logic [11:0] tag_val = '0;
    logic [11:0] b = addr[15:4];
    logic [15:0] ea;
    int          exp_last, exp_cyc;

    exp_last = 8 + lat + ((stall_at < 7) ? stall_len : 0);
    for (int c = 0; c <= exp_last + 1; c++) begin
      miss_detected     = (c <= exp_last) ? 1'b1 : hold;
      miss_address      = (use_alt && c >= 3) ? alt : addr;
      memory_data_valid = 1'b0;
      memory_data       = 16'($urandom);
      if (q.size() > 0 && q[0].ready <= c) begin
        if (ret == stall_at + 1 && stall_left > 0) begin
          stall_left--;
        end else begin
          memory_data_valid = 1'b1;
          memory_data       = mem[q[0].addr[15:1]];
          void'(q.pop_front());
          ret++;
        end
      end
      #1;
      if (memory_req) begin
        if (nreq < 16) begin
          req_cyc[nreq]  = c;
          req_addr[nreq] = memory_address;
        end
        nreq++;
        q.push_back('{memory_address, c + lat});
      end
      if (write_data_array) begin
        if (nwr < 16) begin
          wr_cyc[nwr]  = c;
          wr_word[nwr] = fill_word;
          wr_data[nwr] = fill_data;
        end
        nwr++;
      end
      if (write_tag_array) begin
        tag_cyc = c;
        tag_val = fill_tag;
        ntag++;
      end
      if (fsm_busy && c <= exp_last) nbusy++;
      if (c == exp_last + 1) begin
        n_total++;
        if (fsm_busy !== hold)
          $display("FAIL %s busy_after_fill: got %b want %b (cycle %0d)", name, fsm_busy, hold, c);
        else n_pass++;
      end
      if (abort_after > 0 && nwr == abort_after) begin
        #1;
        rst_n         = 1'b0;
        miss_detected = 1'b0;
        #1;
        n_total++;
        if ({fsm_busy, memory_req, write_data_array, write_tag_array} !== 4'b0 ||
            memory_address !== 16'h0 || fill_tag !== 12'h0)
          $display("FAIL %s async_reset: got busy/req/wr/tag=%b addr=%h tag=%h want all 0",
                   name, {fsm_busy, memory_req, write_data_array, write_tag_array},
                   memory_address, fill_tag);
        else n_pass++;
        memory_data_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        next_cycle();
        return;
      end
      if (c <= exp_last) next_cycle();
    end

    n_total++;
    if (nreq !== 8) $display("FAIL %s req_count: got %0d want 8", name, nreq);
    else n_pass++;
    for (int k = 0; k < 8; k++) begin
      ea = {b, 3'(k), 1'b0};
      n_total++;
      if (req_cyc[k] !== k + 1 || req_addr[k] !== ea)
        $display("FAIL %s req%0d: got cyc=%0d addr=%h want cyc=%0d addr=%h",
                 name, k, req_cyc[k], req_addr[k], k + 1, ea);
      else n_pass++;
    end
    n_total++;
    if (nwr !== 8) $display("FAIL %s write_count: got %0d want 8", name, nwr);
    else n_pass++;
    for (int k = 0; k < 8; k++) begin
      ea      = {b, 3'(k), 1'b0};
      exp_cyc = 1 + k + lat + ((k > stall_at) ? stall_len : 0);
      n_total++;
      if (wr_cyc[k] !== exp_cyc || wr_word[k] !== 3'(k) || wr_data[k] !== mem[ea[15:1]])
        $display("FAIL %s write%0d: got cyc=%0d word=%0d data=%h want cyc=%0d word=%0d data=%h",
                 name, k, wr_cyc[k], wr_word[k], wr_data[k], exp_cyc, k, mem[ea[15:1]]);
      else n_pass++;
    end
    n_total++;
    if (ntag !== 1 || tag_cyc !== exp_last || tag_val !== b)
      $display("FAIL %s tag_write: got n=%0d cyc=%0d tag=%h want n=1 cyc=%0d tag=%h",
               name, ntag, tag_cyc, tag_val, exp_last, b);
    else n_pass++;
    n_total++;
    if (nbusy !== exp_last + 1)
      $display("FAIL %s busy_width: got %0d want %0d", name, nbusy, exp_last + 1);
    else n_pass++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    miss_detected = 1'b0;
    miss_address = 16'h0;
    memory_data = 16'h0;
    memory_data_valid = 1'b0;
    #1;
    n_total++;
    if ({fsm_busy, memory_req, write_data_array, write_tag_array} !== 4'b0 ||
        memory_address !== 16'h0 || fill_word !== 3'h0 || fill_data !== 16'h0 || fill_tag !== 12'h0)
      $display("FAIL reset_outputs: got busy/req/wr/tag=%b addr=%h word=%0d data=%h tag=%h want all 0",
               {fsm_busy, memory_req, write_data_array, write_tag_array},
               memory_address, fill_word, fill_data, fill_tag);
    else n_pass++;
    miss_detected = 1'b1;
    #1;
    n_total++;
    if (fsm_busy !== 1'b1) $display("FAIL reset_busy_follows_miss: got %b want 1", fsm_busy);
    else n_pass++;
    miss_detected = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    next_cycle();
  endtask

  task automatic test_basic_fill();
    run_fill("basic", 16'h1236, 4, 7, 0, 1'b0, 16'h0, 1'b0, 0);
    next_cycle();
  endtask

  task automatic test_stalled_returns();
    run_fill("stall", 16'h5A5A, 4, 4, 3, 1'b0, 16'h0, 1'b0, 0);
    next_cycle();
  endtask

  task automatic test_miss_address_change();
    run_fill("addr_change_first", 16'h1236, 4, 7, 0, 1'b1, 16'h4000, 1'b1, 0);
    run_fill("addr_change_second", 16'h4000, 4, 7, 0, 1'b0, 16'h0, 1'b0, 0);
    next_cycle();
  endtask

  task automatic test_spurious_valid();
    for (int i = 0; i < 4; i++) begin
      miss_detected     = 1'b0;
      memory_data_valid = (i != 2);
      memory_data       = 16'($urandom);
      #1;
      n_total++;
      if ({fsm_busy, memory_req, write_data_array, write_tag_array} !== 4'b0)
        $display("FAIL spurious_valid%0d: got busy/req/wr/tag=%b want 0000", i,
                 {fsm_busy, memory_req, write_data_array, write_tag_array});
      else n_pass++;
      next_cycle();
    end
    memory_data_valid = 1'b0;
    run_fill("after_spurious", 16'($urandom), 3, 7, 0, 1'b0, 16'h0, 1'b0, 0);
    next_cycle();
  endtask

  task automatic test_reset_mid_fill();
    run_fill("reset_mid", 16'h2F48, 4, 7, 0, 1'b0, 16'h0, 1'b0, 4);
    run_fill("after_reset", 16'h8000, 4, 7, 0, 1'b0, 16'h0, 1'b0, 0);
    next_cycle();
  endtask

  task automatic test_latency_sweep();
    run_fill("lat1", 16'($urandom), 1, 7, 0, 1'b0, 16'h0, 1'b0, 0);
    next_cycle();
    run_fill("lat10", 16'($urandom), 10, 7, 0, 1'b0, 16'h0, 1'b0, 0);
    next_cycle();
  endtask

  task automatic test_random_fills();
    for (int i = 0; i < 6; i++) begin
      run_fill($sformatf("rand%0d", i), 16'($urandom), int'($urandom_range(1, 12)),
               int'($urandom_range(0, 7)), int'($urandom_range(0, 4)),
               1'b1, 16'($urandom), 1'b0, 0);
      next_cycle();
    end
  endtask

  task automatic test_back_to_back();
    run_fill("b2b_first", 16'hABC0, 2, 7, 0, 1'b0, 16'h0, 1'b1, 0);
    run_fill("b2b_second", 16'hABC0, 2, 7, 0, 1'b0, 16'h0, 1'b0, 0);
    next_cycle();
  endtask

  initial begin
    for (int i = 0; i < 32768; i++) mem[i] = 16'($urandom);
    test_reset();
    test_basic_fill();
    test_stalled_returns();
    test_miss_address_change();
    test_spurious_valid();
    test_reset_mid_fill();
    test_latency_sweep();
    test_back_to_back();
    test_random_fills();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/cache_fill_fsm.md
# cache_fill_fsm

Miss-handling controller that sits between the pipeline's cache arrays (instruction or data side) and multi-cycle main memory. On a cache miss it stalls the pipeline, streams an aligned 8-word block from main memory, writes each returning word into the cache data array, and writes the tag array on the final word. One instance is used per cache: one behind the IF stage and one behind the MEM stage.

## Interface
- ADDR_W, 16, byte-address width.
- BLOCK_WORDS, 8, 16-bit words per cache block; fixed at 8, so word offset is 3 bits and block is 16 bytes.
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous and active-low.
- miss_detected  in  1  cache lookup missed this cycle; level, held by the cache until fsm_busy falls.
- miss_address  in  ADDR_W  byte address that missed; bits [3:0] ignored.
- fsm_busy  out  1  stall request to the pipeline.
- memory_req  out  1  read request to main memory, one word per asserted cycle.
- memory_address  out  ADDR_W  word byte-address for memory_req.
- memory_data  in  16  read data from main memory.
- memory_data_valid  in  1  memory_data valid this cycle; one pulse per request, in request order.
- write_data_array  out  1  write enable for the cache data array.
- fill_word  out  3  word offset within the block for write_data_array.
- fill_data  out  16  data for write_data_array, equal to memory_data.
- write_tag_array  out  1  write enable for the tag/valid array.
- fill_tag  out  ADDR_W-4  latched miss_address[15:4] for the tag write.

## Operation
- States are IDLE and FILL, encoded in a 1-bit state register.
- IDLE: if miss_detected=1 at the edge, latch base=miss_address[15:4], clear req_cnt and rcv_cnt, and go to FILL. Otherwise stay.
- FILL, issue side: memory_req=1 while req_cnt<8. memory_address={base, req_cnt[2:0], 1'b0}. req_cnt increments on each issued request and is a 4-bit saturating counter.
- FILL, return side: on memory_data_valid=1, drive write_data_array=1, fill_word=rcv_cnt[2:0], fill_data=memory_data, then increment rcv_cnt.
- FILL, completion: when memory_data_valid=1 and rcv_cnt=7, write_tag_array=1 in the same cycle (fill_tag=base), and the next state is IDLE.
- fsm_busy = (state==FILL) | (state==IDLE & miss_detected). It is combinational, so the stall takes effect in the miss cycle itself.
- The same memory_data_valid cycle may coincide with an issuing cycle; the issue and return counters are independent.
- Boundary behaviour:
  - miss_detected and miss_address changes during FILL are ignored.
  - memory_data_valid in IDLE is ignored: no writes, no state change.
  - memory_req is never asserted in IDLE.
  - No more than 8 data writes and exactly 1 tag write occur per fill.
  - Gaps in memory_data_valid extend FILL indefinitely. There is no timeout.
- Reset mid-operation: all state clears immediately and asynchronously. Main memory shares rst_n, so no stale returns occur.

## Timing
- Reset values: state=IDLE, req_cnt=0, rcv_cnt=0, base=0. All outputs are 0 except fsm_busy, which follows miss_detected.
- With miss_detected first high in cycle 0 and memory latency L (4 nominal), the sequence is:
  - cycles 1–8: memory_req=1 for words 0..7.
  - cycles 1+L .. 8+L: write_data_array=1.
  - cycle 8+L: write_tag_array=1.
  - cycle 9+L: state is IDLE.
- fsm_busy is high for cycles 0..8+L, which is 13 cycles at L=4.
- fsm_busy is low in cycle 9+L. The pipeline re-looks-up and hits. A new miss may be accepted at the cycle 9+L edge, giving back-to-back fills with no idle gap beyond that re-lookup cycle.
- Every fill issues exactly 8 memory_req cycles, consecutive, starting the cycle after entry to FILL.

## Test plan
- Basic fill: miss_address=0x1236, L=4.
  - Requests go to 0x1230, 0x1232, …, 0x123E in cycles 1–8.
  - Data writes occur at fill_word 0..7 in cycles 5–12, and fill_data matches the returned words.
  - write_tag_array occurs in cycle 12 with fill_tag=0x123; fsm_busy is low in cycle 13.
- Stalled returns: memory_data_valid deasserted for 3 cycles after word 4.
  - Words 5–7 are written late with offsets unchanged.
  - The tag write occurs on the 8th valid; fsm_busy extends by exactly 3 cycles.
- Miss held and address changed mid-fill: change miss_address to 0x4000 during FILL.
  - All requests stay at base 0x123.
  - After completion, a second fill at 0x4000 starts on the following edge.
- Spurious valid in IDLE: pulse memory_data_valid with no miss.
  - No write_data_array, no write_tag_array, state remains IDLE.
- Reset mid-fill: assert rst_n=0 after word 3 is written.
  - Outputs clear in the same cycle, asynchronously.
  - After release, miss at 0x8000 performs a complete fresh 8-word fill starting at word 0.
- Latency sweep: L=1 and L=10.
  - Exactly 8 requests, 8 data writes, and 1 tag write per fill.
  - fsm_busy width is 9+L.
